// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and a HALT drain sequencer.
// After a HALT is captured, three bubbles drain the pipe before halt_o rises.
module id_ex_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_OP     = 6,
    parameter int N_REGDEST = 2,
    parameter int NB_REG    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [NB_OP-1:0]     opcode_i,
    input  logic                 tipeI_i,
    input  logic                 shamt_i,
    input  logic [N_REGDEST-1:0] regDest_signal_i,
    input  logic [5:0]           mem_signals_i,
    input  logic [2:0]           wb_signals_i,
    input  logic [NB_DATA-1:0]   pc_i,
    input  logic [NB_DATA-1:0]   rs_data_i,
    input  logic [NB_DATA-1:0]   rt_data_i,
    input  logic [NB_DATA-1:0]   imm_i,
    input  logic [NB_REG-1:0]    rs_i,
    input  logic [NB_REG-1:0]    rt_i,
    input  logic [NB_REG-1:0]    rd_i,
    output logic [NB_OP-1:0]     opcode_o,
    output logic                 tipeI_o,
    output logic                 shamt_o,
    output logic [N_REGDEST-1:0] regDest_signal_o,
    output logic [5:0]           mem_signals_o,
    output logic [2:0]           wb_signals_o,
    output logic [NB_DATA-1:0]   pc_o,
    output logic [NB_DATA-1:0]   rs_data_o,
    output logic [NB_DATA-1:0]   rt_data_o,
    output logic [NB_DATA-1:0]   imm_o,
    output logic [NB_REG-1:0]    rs_o,
    output logic [NB_REG-1:0]    rt_o,
    output logic [NB_REG-1:0]    rd_o,
    output logic                 valid_o,
    output logic                 stall_o,
    output logic                 halt_o,
    output logic [1:0]           state_o
);

    localparam logic [NB_OP-1:0] OP_NOP  = NB_OP'(6'b111110);
    localparam logic [NB_OP-1:0] OP_HALT = NB_OP'(6'b111111);
    localparam logic [NB_OP-1:0] OP_BEQ  = NB_OP'(6'b000100);
    localparam logic [NB_OP-1:0] OP_BNE  = NB_OP'(6'b000101);
    localparam logic [NB_OP-1:0] OP_J    = NB_OP'(6'b110001);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [NB_OP-1:0]     opcode_q, opcode_d;
    logic                 tipei_q, tipei_d;
    logic                 shamt_q, shamt_d;
    logic [N_REGDEST-1:0] regdest_q, regdest_d;
    logic [5:0]           mem_q, mem_d;
    logic [2:0]           wb_q, wb_d;
    logic [NB_DATA-1:0]   pc_q, pc_d;
    logic [NB_DATA-1:0]   rs_data_q, rs_data_d;
    logic [NB_DATA-1:0]   rt_data_q, rt_data_d;
    logic [NB_DATA-1:0]   imm_q, imm_d;
    logic [NB_REG-1:0]    rs_q, rs_d;
    logic [NB_REG-1:0]    rt_q, rt_d;
    logic [NB_REG-1:0]    rd_q, rd_d;
    logic                 valid_q, valid_d;

    logic stall;
    logic no_writeback;

    // A load in EX whose destination is read by the instruction in ID.
    assign stall = mem_q[4] && valid_q && (rt_q != '0) && ((rt_q == rs_i) || (rt_q == rt_i));

    assign no_writeback = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE) ||
                          (opcode_i == OP_J)   || (opcode_i == OP_HALT);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a flushed or stalled HALT is not captured.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (enable) begin
            case (state_q)
                ST_RUN: begin
                    if (!flush && !stall && (opcode_i == OP_HALT)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 2'd2) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: state_d = ST_HALTED;
            endcase
        end
    end

    // Output decode
    always_comb begin
        halt_o  = (state_q == ST_HALTED);
        state_o = state_q;
        stall_o = stall;
    end

    // Pipeline register next values
    always_comb begin
        opcode_d  = opcode_q;
        tipei_d   = tipei_q;
        shamt_d   = shamt_q;
        regdest_d = regdest_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        if (enable) begin
            if (flush || (state_q != ST_RUN) || stall) begin
                opcode_d  = OP_NOP;
                tipei_d   = 1'b0;
                shamt_d   = 1'b0;
                regdest_d = '0;
                mem_d     = '0;
                wb_d      = '0;
                pc_d      = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                rs_d      = '0;
                rt_d      = '0;
                rd_d      = '0;
                valid_d   = 1'b0;
            end else begin
                opcode_d  = opcode_i;
                tipei_d   = tipeI_i;
                shamt_d   = shamt_i;
                regdest_d = regDest_signal_i;
                mem_d     = mem_signals_i;
                wb_d      = no_writeback ? 3'b000 : wb_signals_i;
                pc_d      = pc_i;
                rs_data_d = rs_data_i;
                rt_data_d = rt_data_i;
                imm_d     = imm_i;
                rs_d      = rs_i;
                rt_d      = rt_i;
                rd_d      = rd_i;
                valid_d   = (opcode_i != OP_NOP);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_q  <= OP_NOP;
            tipei_q   <= 1'b0;
            shamt_q   <= 1'b0;
            regdest_q <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            opcode_q  <= opcode_d;
            tipei_q   <= tipei_d;
            shamt_q   <= shamt_d;
            regdest_q <= regdest_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
        end
    end

    assign opcode_o         = opcode_q;
    assign tipeI_o          = tipei_q;
    assign shamt_o          = shamt_q;
    assign regDest_signal_o = regdest_q;
    assign mem_signals_o    = mem_q;
    assign wb_signals_o     = wb_q;
    assign pc_o             = pc_q;
    assign rs_data_o        = rs_data_q;
    assign rt_data_o        = rt_data_q;
    assign imm_o            = imm_q;
    assign rs_o             = rs_q;
    assign rt_o             = rt_q;
    assign rd_o             = rd_q;
    assign valid_o          = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load path, load-use stall, branch write-back
// suppression, flush, and the HALT drain / reset sequence.
module tb_id_ex_stage;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b110001;
    localparam logic [5:0] OP_NOP  = 6'b111110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        clock, reset, enable, flush;
    logic [5:0]  opcode_i;
    logic        tipeI_i, shamt_i;
    logic [1:0]  regDest_signal_i;
    logic [5:0]  mem_signals_i;
    logic [2:0]  wb_signals_i;
    logic [31:0] pc_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [5:0]  opcode_o;
    logic        tipeI_o, shamt_o;
    logic [1:0]  regDest_signal_o;
    logic [5:0]  mem_signals_o;
    logic [2:0]  wb_signals_o;
    logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        valid_o, stall_o, halt_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .opcode_i(opcode_i), .tipeI_i(tipeI_i), .shamt_i(shamt_i),
        .regDest_signal_i(regDest_signal_i), .mem_signals_i(mem_signals_i),
        .wb_signals_i(wb_signals_i), .pc_i(pc_i), .rs_data_i(rs_data_i),
        .rt_data_i(rt_data_i), .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .opcode_o(opcode_o), .tipeI_o(tipeI_o), .shamt_o(shamt_o),
        .regDest_signal_o(regDest_signal_o), .mem_signals_o(mem_signals_o),
        .wb_signals_o(wb_signals_o), .pc_o(pc_o), .rs_data_o(rs_data_o),
        .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .valid_o(valid_o), .stall_o(stall_o), .halt_o(halt_o), .state_o(state_o)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic ti, input logic [5:0] mem,
                          input logic [2:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] imm);
        opcode_i         = op;
        tipeI_i          = ti;
        shamt_i          = 1'b0;
        regDest_signal_i = 2'b01;
        mem_signals_i    = mem;
        wb_signals_i     = wb;
        pc_i             = 32'h0000_0400 + imm;
        rs_data_i        = 32'h1000_0000 + {27'd0, rs};
        rt_data_i        = 32'h2000_0000 + {27'd0, rt};
        imm_i            = imm;
        rs_i             = rs;
        rt_i             = rt;
        rd_i             = 5'd0;
    endtask

    task automatic set_nop();
        set_id(OP_NOP, 1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic set_addi();
        set_id(OP_ADDI, 1'b1, 6'd0, 3'b101, 5'd3, 5'd4, 32'h5);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0;
        enable = 1'b1;
        set_nop();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        flush = 1'b0;
        set_addi();
        tick();
        tick();
        checks++; if (opcode_o !== OP_NOP) begin failures++; $display("FAIL reset_opcode got=%h exp=%h", opcode_o, OP_NOP); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if ({tipeI_o, regDest_signal_o, mem_signals_o, wb_signals_o} !== 12'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {tipeI_o, regDest_signal_o, mem_signals_o, wb_signals_o}); end
        checks++; if ({pc_o, imm_o, rs_o, rt_o} !== 74'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {pc_o, imm_o, rs_o, rt_o}); end
        checks++; if (halt_o !== 1'b0 || state_o !== 2'd0) begin failures++; $display("FAIL reset_fsm got halt=%b state=%0d exp halt=0 state=0", halt_o, state_o); end
        reset = 1'b1;
    endtask

    task automatic test_addi();
        set_addi();
        tick();
        checks++; if (opcode_o !== OP_ADDI) begin failures++; $display("FAIL addi_opcode got=%h exp=%h", opcode_o, OP_ADDI); end
        checks++; if (tipeI_o !== 1'b1 || valid_o !== 1'b1) begin failures++; $display("FAIL addi_tipei_valid got=%b%b exp=11", tipeI_o, valid_o); end
        checks++; if (wb_signals_o !== 3'b101) begin failures++; $display("FAIL addi_wb got=%b exp=101", wb_signals_o); end
        checks++; if (imm_o !== 32'h5 || pc_o !== 32'h405) begin failures++; $display("FAIL addi_imm_pc got=%h/%h exp=5/405", imm_o, pc_o); end
        checks++; if (rs_o !== 5'd3 || rt_o !== 5'd4 || rs_data_o !== 32'h1000_0003 || rt_data_o !== 32'h2000_0004) begin failures++; $display("FAIL addi_regs got=%0d %0d %h %h exp=3 4 10000003 20000004", rs_o, rt_o, rs_data_o, rt_data_o); end
        checks++; if (regDest_signal_o !== 2'b01) begin failures++; $display("FAIL addi_regdest got=%b exp=01", regDest_signal_o); end
    endtask

    task automatic test_enable_hold();
        enable = 1'b0;
        set_id(OP_BNE, 1'b0, 6'd0, 3'b100, 5'd9, 5'd10, 32'h77);
        tick();
        checks++; if (opcode_o !== OP_ADDI || imm_o !== 32'h5 || valid_o !== 1'b1) begin failures++; $display("FAIL hold_outputs got=%h %h %b exp=08 5 1", opcode_o, imm_o, valid_o); end
        enable = 1'b1;
        set_id(OP_NOP, 1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 32'h7);
        tick();
        checks++; if (opcode_o !== OP_NOP || valid_o !== 1'b0) begin failures++; $display("FAIL nop_valid got=%h %b exp=3e 0", opcode_o, valid_o); end
    endtask

    task automatic test_load_use();
        set_id(OP_LW, 1'b1, 6'b010001, 3'b101, 5'd2, 5'd8, 32'h10);
        tick();
        checks++; if (mem_signals_o !== 6'b010001 || rt_o !== 5'd8) begin failures++; $display("FAIL lw_load got=%b %0d exp=010001 8", mem_signals_o, rt_o); end
        set_id(OP_ADDI, 1'b1, 6'd0, 3'b101, 5'd8, 5'd9, 32'h1);
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL stall_rs got=%b exp=1", stall_o); end
        tick();
        checks++; if (opcode_o !== OP_NOP || valid_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL stall_bubble got=%h %b %b exp=3e 0 0", opcode_o, valid_o, stall_o); end
        tick();
        checks++; if (opcode_o !== OP_ADDI || rs_o !== 5'd8 || valid_o !== 1'b1) begin failures++; $display("FAIL stall_reissue got=%h %0d %b exp=08 8 1", opcode_o, rs_o, valid_o); end
        // rt match, and stall still visible while the pipe is frozen
        set_id(OP_LW, 1'b1, 6'b010001, 3'b101, 5'd2, 5'd8, 32'h10);
        tick();
        set_id(OP_ADDI, 1'b1, 6'd0, 3'b101, 5'd1, 5'd8, 32'h1);
        enable = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL stall_rt_frozen got=%b exp=1", stall_o); end
        tick();
        checks++; if (opcode_o !== OP_LW || stall_o !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h %b exp=23 1", opcode_o, stall_o); end
        enable = 1'b1;
        tick();
        checks++; if (opcode_o !== OP_NOP || stall_o !== 1'b0) begin failures++; $display("FAIL stall_rt_bubble got=%h %b exp=3e 0", opcode_o, stall_o); end
        set_id(OP_LW, 1'b1, 6'b010001, 3'b101, 5'd2, 5'd0, 32'h10);
        tick();
        set_id(OP_ADDI, 1'b1, 6'd0, 3'b101, 5'd0, 5'd0, 32'h1);
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stall_r0 got=%b exp=0", stall_o); end
        set_id(OP_LW, 1'b1, 6'b010001, 3'b101, 5'd2, 5'd8, 32'h10);
        tick();
        set_id(OP_ADDI, 1'b1, 6'd0, 3'b101, 5'd5, 5'd6, 32'h1);
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stall_nomatch got=%b exp=0", stall_o); end
    endtask

    task automatic test_branch_x();
        set_id(OP_BEQ, 1'b0, 6'd0, 3'bxxx, 5'd1, 5'd2, 32'h8);
        tick();
        checks++; if (wb_signals_o !== 3'b000 || valid_o !== 1'b1 || opcode_o !== OP_BEQ) begin failures++; $display("FAIL beq_wb got=%b %b %h exp=000 1 04", wb_signals_o, valid_o, opcode_o); end
        flush = 1'b1;
        tick();
        checks++; if (opcode_o !== OP_NOP || valid_o !== 1'b0 || wb_signals_o !== 3'b000 || imm_o !== 32'd0) begin failures++; $display("FAIL beq_flush got=%h %b %b %h exp=3e 0 000 0", opcode_o, valid_o, wb_signals_o, imm_o); end
        flush = 1'b0;
        set_id(OP_J, 1'b0, 6'd0, 3'b110, 5'd0, 5'd0, 32'h20);
        tick();
        checks++; if (wb_signals_o !== 3'b000 || opcode_o !== OP_J) begin failures++; $display("FAIL j_wb got=%b %h exp=000 31", wb_signals_o, opcode_o); end
    endtask

    task automatic test_halt_drain();
        set_id(OP_HALT, 1'b0, 6'd0, 3'b100, 5'd0, 5'd0, 32'd0);
        tick();
        checks++; if (opcode_o !== OP_HALT || valid_o !== 1'b1 || wb_signals_o !== 3'b000 || halt_o !== 1'b0 || state_o !== 2'd1) begin failures++; $display("FAIL halt_capture got=%h %b %b %b %0d exp=3f 1 000 0 1", opcode_o, valid_o, wb_signals_o, halt_o, state_o); end
        set_addi();
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (opcode_o !== OP_NOP || valid_o !== 1'b0 || halt_o !== 1'b0) begin failures++; $display("FAIL drain_bubble%0d got=%h %b %b exp=3e 0 0", i, opcode_o, valid_o, halt_o); end
        end
        tick();
        checks++; if (halt_o !== 1'b1 || state_o !== 2'd2 || opcode_o !== OP_NOP) begin failures++; $display("FAIL halt_rise got=%b %0d %h exp=1 2 3e", halt_o, state_o, opcode_o); end
        tick();
        checks++; if (halt_o !== 1'b1 || opcode_o !== OP_NOP || valid_o !== 1'b0) begin failures++; $display("FAIL halted_stays got=%b %h %b exp=1 3e 0", halt_o, opcode_o, valid_o); end
    endtask

    task automatic test_reset_halted();
        #3;
        reset = 1'b0;
        #1;
        checks++; if (halt_o !== 1'b0 || state_o !== 2'd0 || opcode_o !== OP_NOP || valid_o !== 1'b0) begin failures++; $display("FAIL async_reset got=%b %0d %h %b exp=0 0 3e 0", halt_o, state_o, opcode_o, valid_o); end
        #1;
        reset = 1'b1;
        tick();
        checks++; if (opcode_o !== OP_ADDI || valid_o !== 1'b1 || halt_o !== 1'b0) begin failures++; $display("FAIL post_reset_addi got=%h %b %b exp=08 1 0", opcode_o, valid_o, halt_o); end
    endtask

    task automatic test_drain_gap();
        set_id(OP_HALT, 1'b0, 6'd0, 3'b000, 5'd0, 5'd0, 32'd0);
        tick();
        set_addi();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (halt_o !== 1'b0 || state_o !== 2'd1) begin failures++; $display("FAIL gap_frozen%0d got=%b %0d exp=0 1", i, halt_o, state_o); end
        end
        enable = 1'b1;
        tick();
        checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL gap_early got=%b exp=0", halt_o); end
        tick();
        checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL gap_halt got=%b exp=1", halt_o); end
    endtask

    task automatic test_flush_halt();
        set_id(OP_HALT, 1'b0, 6'd0, 3'b000, 5'd0, 5'd0, 32'd0);
        flush = 1'b1;
        tick();
        checks++; if (opcode_o !== OP_NOP || valid_o !== 1'b0 || state_o !== 2'd0) begin failures++; $display("FAIL flush_halt got=%h %b %0d exp=3e 0 0", opcode_o, valid_o, state_o); end
        flush = 1'b0;
        set_nop();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL flush_no_halt%0d got=%b exp=0", i, halt_o); end
        end
        set_addi();
        tick();
        checks++; if (opcode_o !== OP_ADDI || valid_o !== 1'b1) begin failures++; $display("FAIL flush_then_addi got=%h %b exp=08 1", opcode_o, valid_o); end
    endtask

    task automatic test_flush_drain();
        set_id(OP_HALT, 1'b0, 6'd0, 3'b000, 5'd0, 5'd0, 32'd0);
        tick();
        flush = 1'b1;
        set_addi();
        tick();
        tick();
        tick();
        checks++; if (halt_o !== 1'b1 || state_o !== 2'd2) begin failures++; $display("FAIL flush_drain got=%b %0d exp=1 2", halt_o, state_o); end
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        flush = 1'b0;
        set_nop();
        test_reset();
        test_addi();
        test_enable_hold();
        test_load_use();
        test_branch_x();
        do_reset();
        test_halt_drain();
        test_reset_halted();
        do_reset();
        test_drain_gap();
        do_reset();
        test_flush_halt();
        do_reset();
        test_flush_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: NB_DATA, 32, datapath width; NB_OP, 6, opcode width; N_REGDEST, 2, destination-select width; NB_REG, 5, register-index width.
REQ-002 SHALL have ports: clock  in  1  single clock, all state on rising edge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: enable  in  1  pipeline advance (debug step); flush  in  1  branch/jump taken, kill ID instruction.
REQ-004 SHALL have ports: opcode_i  in  NB_OP; tipeI_i, shamt_i  in  1 each; regDest_signal_i  in  N_REGDEST; mem_signals_i  in  6  (5 sign, 4 read, 3 write, 2-0 W/H/B); wb_signals_i  in  3  (2 regWrite, 1-0 mem_to_reg).
REQ-005 SHALL have ports: pc_i, rs_data_i, rt_data_i, imm_i  in  NB_DATA each; rs_i, rt_i, rd_i  in  NB_REG each.
REQ-006 SHALL have registered outputs: the *_o counterpart of every REQ-004/005 input, same width, plus valid_o  out  1  EX slot holds a real instruction.
REQ-007 SHALL have outputs: stall_o  out  1  load-use stall to PC/IF-ID (combinational); halt_o  out  1  pipeline drained after HALT (registered).

Function
REQ-008 Bubble SHALL mean: opcode_o=6'b111110 (NOP), all other control outputs 0, valid_o=0, data/index outputs 0.
REQ-009 stall_o SHALL be 1 when mem_signals_o[4]=1 and valid_o=1 and rt_o!=0 and (rt_o==rs_i or rt_o==rt_i); else 0.
REQ-010 On each rising edge, update priority SHALL be: enable=0 -> hold all state; else flush=1 -> bubble; else FSM not RUN -> bubble; else stall_o=1 -> bubble; else load inputs.
REQ-011 On load, wb_signals_o SHALL be 3'b000 when opcode_i is BEQ (000100), BNE (000101), J (110001) or HALT (111111), otherwise wb_signals_i; X inputs never propagate.
REQ-012 On load, valid_o SHALL be 1 unless opcode_i is NOP (111110).
REQ-013 Latency SHALL be 1 enabled cycle from ID inputs to EX outputs.
REQ-014 FSM states SHALL be RUN, DRAIN, HALTED.
REQ-015 RUN->DRAIN SHALL occur on an edge where enable=1, flush=0, stall_o=0, opcode_i=111111; the HALT is loaded (valid_o=1, opcode_o=111111) and a 2-bit drain counter is set to 0.
REQ-016 In DRAIN the counter SHALL increment on each enabled edge; on the edge where it equals 2, state SHALL go to HALTED (third enabled edge after HALT capture).
REQ-017 HALTED SHALL be exited only by reset; halt_o=1 exactly while in HALTED.
REQ-018 flush coincident with HALT in ID SHALL win: bubble loaded, state stays RUN.
REQ-019 flush during DRAIN SHALL NOT cancel the drain.
REQ-020 enable=0 SHALL freeze FSM and counter; stall_o still evaluates combinationally.
REQ-021 stall SHALL self-clear after one enabled edge, since the bubble clears mem_signals_o[4].

Reset
REQ-022 reset=0 SHALL asynchronously force: all outputs to bubble values (REQ-008), FSM=RUN, counter=0, halt_o=0.
REQ-023 Deassertion SHALL be captured on the next rising edge; first load occurs on the first enabled edge after deassertion.
REQ-024 reset mid-DRAIN or in HALTED SHALL return to RUN with no residual halt_o.

Verification
REQ-025 ADDI (001000), rs=3, rt=4, imm=0x5 -> next edge: opcode_o=001000, tipeI_o=1, wb_signals_o=101, valid_o=1, imm_o=0x5.
REQ-026 LW rt=8 in EX, ID instr rs_i=8 -> stall_o=1; next edge opcode_o=111110, valid_o=0, stall_o=0; with rt_o=0 instead -> stall_o=0.
REQ-027 BEQ with wb_signals_i=3'bxxx -> wb_signals_o=000, valid_o=1; same with flush=1 -> bubble.
REQ-028 HALT with enable=1 -> 3 bubbles after HALT in EX, halt_o=1 on third enabled edge; insert enable=0 for 2 cycles mid-drain -> halt_o delayed by exactly 2 cycles.
REQ-029 HALT in ID with flush=1 -> bubble, FSM RUN, halt_o never asserts; later ADDI loads normally.
REQ-030 reset=0 pulsed asynchronously (between edges) while HALTED -> outputs immediately bubble, halt_o=0; after release, ADDI loads on first enabled edge.
